bmd_64_wdma_desc_sched: RTL and testbench
=========================================

BMD_64_WDMA_DESC_SCHED -- requirements
Module: BMD_64_WDMA_DESC_SCHED

Interface
REQ-001 SHALL have parameter DEPTH, default 4, descriptor queue entries (power of 2, 2..16).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- init_rst_i  in  1  soft reset; same effect as rst.
- desc_wr_i  in  1  one-cycle push strobe for a host buffer descriptor.
- desc_addr_i  in  32  buffer address bits [31:0].
- desc_up_addr_i  in  8  buffer address bits [39:32].
- desc_len_i  in  16  buffer length in frames.
- sched_start_i  in  1  host start pulse.
- sched_stop_i  in  1  host stop pulse.
- wdma_running_i  in  1  running flag from the write DMA FSM.
- wdma_irq_i  in  1  IRQ pulse from the write DMA FSM.
- wdma_status_i  in  4  status from the write DMA FSM.
- next_wdma_addr_o  out  32  head descriptor address [31:0].
- next_wdma_up_addr_o  out  8  head descriptor address [39:32].
- next_wdma_valid_o  out  1  one-cycle "head valid" pulse to the FSM.
- wdma_start_o  out  1  one-cycle start pulse to the FSM.
- wdma_stop_o  out  1  one-cycle stop pulse to the FSM.
- wdma_frame_len_o  out  16  length of the buffer the FSM is currently filling.
- sched_busy_o  out  1  high outside IDLE.
- sched_irq_o  out  1  one-cycle end-of-session pulse to the host.
- sched_status_o  out  4  last terminal FSM status.
- bufs_done_o  out  16  buffers completed this session.
- desc_count_o  out  5  queued descriptors.
- overflow_o  out  1  sticky; a push was dropped.

Function
REQ-003 SHALL store {up_addr, addr, len} in a DEPTH-entry FIFO; desc_wr_i pushes when count<DEPTH, otherwise drops the descriptor and sets overflow_o.
REQ-004 next_wdma_addr_o / next_wdma_up_addr_o SHALL show the FIFO head combinationally; they are 0 when the FIFO is empty.
REQ-005 SHALL implement the states IDLE, PRIME, KICK, ACTIVE and DONE.
REQ-006 IDLE: on sched_start_i with count!=0, go to PRIME; sched_start_i with count==0 is ignored.
REQ-007 PRIME: pulse next_wdma_valid_o, set armed=1, go to KICK.
REQ-008 KICK: pulse wdma_start_o, clear bufs_done_o, go to ACTIVE. The valid pulse therefore always precedes the start pulse by exactly 1 cycle.
REQ-009 Consume event, part 1: a rising edge of wdma_running_i while armed.
REQ-010 Consume event, part 2: wdma_status_i==4'b0001 sampled exactly 1 cycle after a wdma_irq_i pulse, while armed. The status lags the IRQ by one cycle.
REQ-011 On a consume event: pop the head, load wdma_frame_len_o with the popped len, clear armed.
REQ-012 On a 4'b0001 consume event only, also increment bufs_done_o (16-bit, wraps).
REQ-013 ACTIVE: when armed==0 and count!=0, pulse next_wdma_valid_o and set armed=1. The pulse SHALL NOT fire in the cycle of a consume event. At most one unconsumed valid is outstanding.
REQ-014 ACTIVE: wdma_status_i in {0010, 0011, 0100, 1000}, sampled 1 cycle after wdma_irq_i, SHALL latch into sched_status_o and go to DONE.
REQ-015 In the terminal case of REQ-014, status 0011 SHALL also increment bufs_done_o.
REQ-016 ACTIVE: sched_stop_i SHALL produce one wdma_stop_o pulse; the state stays ACTIVE until a terminal status arrives.
REQ-017 In states other than ACTIVE, sched_stop_i SHALL be ignored.
REQ-018 DONE: once wdma_running_i==0, go to IDLE, pulse sched_irq_o, clear armed.
REQ-019 On leaving DONE, an entry that was armed but never consumed SHALL remain queued as the head.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and keep both operations correct.
REQ-021 A push while full SHALL be dropped even in a cycle that also pops.
REQ-022 wdma_frame_len_o SHALL change only on a consume event; it is stable during a buffer fill.
REQ-023 wdma_irq_i seen in IDLE, PRIME or KICK SHALL be ignored.
REQ-024 sched_busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-025 rst or init_rst_i SHALL empty the FIFO and return to IDLE on the next edge, including mid-session. No pulse output fires in that cycle.
REQ-026 Reset values SHALL be: all outputs 0, armed=0, count=0, overflow_o=0, sched_status_o=0.
REQ-027 init_rst_i SHALL behave identically to rst, and SHALL take priority over all other inputs in the same cycle.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Push A(0x10_0000_1000, len 8), B(0x10_0000_2000, len 4), then start -> valid pulse with head A; start pulse 1 cycle later; running rises -> frame_len=8, head=B, a second valid pulse follows.
- FSM IRQ followed 1 cycle later by status 0001 -> frame_len=4, bufs_done_o=1, count=0, no further valid pulse.
- After B, IRQ then status 0011 -> sched_status_o=0011, bufs_done_o=2; running falls -> single sched_irq_o pulse, busy=0.
- DEPTH+1 pushes -> count=DEPTH, overflow_o=1, the extra descriptor is absent; push and pop in the same cycle -> count unchanged.
- sched_stop_i in ACTIVE -> one wdma_stop_o pulse; status 0100 -> DONE, then IDLE; the armed entry remains the head.
- init_rst_i mid-session with 3 entries queued -> next cycle count=0, IDLE, all outputs 0.

Source files
------------

// File: rtl/bmd_64_wdma_desc_sched.sv
// Write-DMA descriptor scheduler: queues host buffer descriptors and hands them one at a time to the write DMA FSM.
// Control pulses are registered one edge after their cause; the queue head is combinational; pushes into a full queue are dropped.
module bmd_64_wdma_desc_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_rst_i,
  input  logic        desc_wr_i,
  input  logic [31:0] desc_addr_i,
  input  logic [7:0]  desc_up_addr_i,
  input  logic [15:0] desc_len_i,
  input  logic        sched_start_i,
  input  logic        sched_stop_i,
  input  logic        wdma_running_i,
  input  logic        wdma_irq_i,
  input  logic [3:0]  wdma_status_i,
  output logic [31:0] next_wdma_addr_o,
  output logic [7:0]  next_wdma_up_addr_o,
  output logic        next_wdma_valid_o,
  output logic        wdma_start_o,
  output logic        wdma_stop_o,
  output logic [15:0] wdma_frame_len_o,
  output logic        sched_busy_o,
  output logic        sched_irq_o,
  output logic [3:0]  sched_status_o,
  output logic [15:0] bufs_done_o,
  output logic [4:0]  desc_count_o,
  output logic        overflow_o
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]      DEPTH_C = 5'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);

  typedef struct packed {
    logic [7:0]  up;
    logic [31:0] addr;
    logic [15:0] len;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_KICK,
    S_ACTIVE,
    S_DONE
  } state_t;

  desc_t         mem_q [DEPTH];
  desc_t         head;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          armed_q, armed_d;
  logic          running_q, running_d;
  logic          irq_seen_q, irq_seen_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          irq_q, irq_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   frame_len_q, frame_len_d;
  logic [15:0]   bufs_done_q, bufs_done_d;
  logic [3:0]    status_q, status_d;
  logic          push, pop, rise, st_done, st_term;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    push    = desc_wr_i && (count_q < DEPTH_C);
    rise    = wdma_running_i && !running_q;
    // Status is only meaningful the cycle after an IRQ taken in ACTIVE.
    st_done = irq_seen_q && (wdma_status_i == 4'b0001);
    st_term = irq_seen_q && (wdma_status_i inside {4'b0010, 4'b0011, 4'b0100, 4'b1000});
    pop     = armed_q && (count_q != 5'd0) && (rise || st_done);

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    armed_d     = armed_q;
    running_d   = wdma_running_i;
    irq_seen_d  = wdma_irq_i && (state_q == S_ACTIVE);
    valid_d     = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    irq_d       = 1'b0;
    overflow_d  = overflow_q || (desc_wr_i && !push);
    frame_len_d = frame_len_q;
    bufs_done_d = bufs_done_q;
    status_d    = status_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      frame_len_d = head.len;
      armed_d     = 1'b0;
      if (st_done) bufs_done_d = bufs_done_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (sched_start_i && (count_q != 5'd0)) begin
          state_d = S_PRIME;
          valid_d = 1'b1;
          armed_d = 1'b1;
        end
      end
      S_PRIME: begin
        state_d     = S_KICK;
        start_d     = 1'b1;
        bufs_done_d = '0;
      end
      S_KICK: state_d = S_ACTIVE;
      S_ACTIVE: begin
        stop_d = sched_stop_i;
        if (st_term) begin
          status_d = wdma_status_i;
          state_d  = S_DONE;
          if (wdma_status_i == 4'b0011) bufs_done_d = bufs_done_d + 16'd1;
        end else if (!armed_q && (count_q != 5'd0)) begin
          valid_d = 1'b1;
          armed_d = 1'b1;
        end
      end
      S_DONE: begin
        // An armed-but-unconsumed head stays queued for the next session.
        if (!wdma_running_i) begin
          state_d = S_IDLE;
          irq_d   = 1'b1;
          armed_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= desc_t'{up: desc_up_addr_i, addr: desc_addr_i, len: desc_len_i};
  end

  always_ff @(posedge clk) begin
    if (rst || init_rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      armed_q     <= 1'b0;
      running_q   <= 1'b0;
      irq_seen_q  <= 1'b0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      irq_q       <= 1'b0;
      overflow_q  <= 1'b0;
      frame_len_q <= '0;
      bufs_done_q <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      armed_q     <= armed_d;
      running_q   <= running_d;
      irq_seen_q  <= irq_seen_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      irq_q       <= irq_d;
      overflow_q  <= overflow_d;
      frame_len_q <= frame_len_d;
      bufs_done_q <= bufs_done_d;
      status_q    <= status_d;
    end
  end

  assign next_wdma_addr_o    = (count_q != 5'd0) ? head.addr : 32'h0;
  assign next_wdma_up_addr_o = (count_q != 5'd0) ? head.up : 8'h0;
  assign next_wdma_valid_o   = valid_q;
  assign wdma_start_o        = start_q;
  assign wdma_stop_o         = stop_q;
  assign wdma_frame_len_o    = frame_len_q;
  assign sched_busy_o        = (state_q != S_IDLE);
  assign sched_irq_o         = irq_q;
  assign sched_status_o      = status_q;
  assign bufs_done_o         = bufs_done_q;
  assign desc_count_o        = count_q;
  assign overflow_o          = overflow_q;

endmodule

// File: tb/tb_bmd_64_wdma_desc_sched.sv
// Bench for the write-DMA descriptor scheduler: queue-based reference model plus a pulse scoreboard.
module tb_bmd_64_wdma_desc_sched;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, init_rst_i, desc_wr_i, sched_start_i, sched_stop_i;
  logic        wdma_running_i, wdma_irq_i;
  logic [31:0] desc_addr_i;
  logic [7:0]  desc_up_addr_i;
  logic [15:0] desc_len_i;
  logic [3:0]  wdma_status_i;
  logic [31:0] next_wdma_addr_o;
  logic [7:0]  next_wdma_up_addr_o;
  logic        next_wdma_valid_o, wdma_start_o, wdma_stop_o, sched_busy_o, sched_irq_o, overflow_o;
  logic [15:0] wdma_frame_len_o, bufs_done_o;
  logic [3:0]  sched_status_o;
  logic [4:0]  desc_count_o;

  bmd_64_wdma_desc_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .init_rst_i(init_rst_i), .desc_wr_i(desc_wr_i),
    .desc_addr_i(desc_addr_i), .desc_up_addr_i(desc_up_addr_i), .desc_len_i(desc_len_i),
    .sched_start_i(sched_start_i), .sched_stop_i(sched_stop_i),
    .wdma_running_i(wdma_running_i), .wdma_irq_i(wdma_irq_i), .wdma_status_i(wdma_status_i),
    .next_wdma_addr_o(next_wdma_addr_o), .next_wdma_up_addr_o(next_wdma_up_addr_o),
    .next_wdma_valid_o(next_wdma_valid_o), .wdma_start_o(wdma_start_o), .wdma_stop_o(wdma_stop_o),
    .wdma_frame_len_o(wdma_frame_len_o), .sched_busy_o(sched_busy_o), .sched_irq_o(sched_irq_o),
    .sched_status_o(sched_status_o), .bufs_done_o(bufs_done_o), .desc_count_o(desc_count_o),
    .overflow_o(overflow_o)
  );

  typedef struct packed {
    logic [7:0]  up;
    logic [31:0] addr;
    logic [15:0] len;
  } d_t;
  typedef enum {M_IDLE, M_ACT, M_DONE} m_st_t;

  d_t          mq[$];
  logic [39:0] exp_valid_q[$];
  logic [19:0] exp_irq_q[$];
  int          exp_start = 0, exp_stop = 0;
  m_st_t       m_state;
  bit          m_armed, m_ovf, cur_run, mon_en;
  logic [15:0] m_frame, m_bufs;
  logic [3:0]  m_status;
  int          checks = 0, failures = 0, cyc = 0, valid_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic d_t rand_desc();
    return d_t'{up: 8'($urandom), addr: $urandom, len: 16'($urandom_range(1, 2048))};
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_state = M_IDLE; m_armed = 0; m_ovf = 0; m_frame = 0; m_bufs = 0; m_status = 0;
  endfunction

  // Whenever a session is active and nothing is outstanding, the head is offered.
  function automatic void rearm();
    if (m_state == M_ACT && !m_armed && mq.size() > 0) begin
      exp_valid_q.push_back({mq[0].up, mq[0].addr});
      m_armed = 1;
    end
  endfunction

  function automatic void consume(bit by_status);
    d_t d;
    d = mq.pop_front();
    m_frame = d.len;
    m_armed = 0;
    if (by_status) m_bufs++;
  endfunction

  function automatic void end_session();
    exp_irq_q.push_back({m_status, m_bufs});
    m_state = M_IDLE;
    m_armed = 0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic push_desc(d_t d);
    desc_wr_i = 1; desc_addr_i = d.addr; desc_up_addr_i = d.up; desc_len_i = d.len;
    if (mq.size() < DEPTH) mq.push_back(d); else m_ovf = 1;
    rearm();
    step();
    desc_wr_i = 0;
    idle(2);
  endtask

  task automatic start_sess();
    if (m_state == M_IDLE && mq.size() > 0) begin
      exp_valid_q.push_back({mq[0].up, mq[0].addr});
      m_armed = 1; m_state = M_ACT; m_bufs = 0; exp_start++;
    end
    sched_start_i = 1; step(); sched_start_i = 0;
    idle(4);
  endtask

  task automatic stop_sess();
    if (m_state == M_ACT) exp_stop++;
    sched_stop_i = 1; step(); sched_stop_i = 0;
    idle(2);
  endtask

  task automatic set_running(bit v);
    if (v && !cur_run && m_armed) begin consume(0); rearm(); end
    if (!v && m_state == M_DONE) end_session();
    cur_run = v; wdma_running_i = v;
    step(); idle(3);
  endtask

  task automatic irq_status(input logic [3:0] s, input bit do_push, input d_t d);
    bit acc;
    wdma_irq_i = 1; step(); wdma_irq_i = 0; wdma_status_i = s;
    if (do_push) begin
      desc_wr_i = 1; desc_addr_i = d.addr; desc_up_addr_i = d.up; desc_len_i = d.len;
    end
    acc = do_push && (mq.size() < DEPTH);
    if (do_push && !acc) m_ovf = 1;
    if (m_state == M_ACT) begin
      if (s == 4'b0001 && m_armed) consume(1);
      else if (s inside {4'b0010, 4'b0011, 4'b0100, 4'b1000}) begin
        m_status = s;
        if (s == 4'b0011) m_bufs++;
        m_state = M_DONE;
      end
    end
    if (acc) mq.push_back(d);
    if (m_state == M_DONE && !cur_run) end_session();
    rearm();
    step();
    wdma_status_i = 0; desc_wr_i = 0;
    idle(3);
  endtask

  task automatic check_state(string tag);
    logic [39:0] eh;
    eh = (mq.size() > 0) ? {mq[0].up, mq[0].addr} : 40'h0;
    @(negedge clk);
    chk({tag, ".count"}, desc_count_o, mq.size());
    chk({tag, ".overflow"}, overflow_o, m_ovf);
    chk({tag, ".frame_len"}, wdma_frame_len_o, m_frame);
    chk({tag, ".bufs_done"}, bufs_done_o, m_bufs);
    chk({tag, ".busy"}, sched_busy_o, m_state != M_IDLE);
    chk({tag, ".status"}, sched_status_o, m_status);
    chk({tag, ".head"}, {next_wdma_up_addr_o, next_wdma_addr_o}, eh);
  endtask

  task automatic check_pulses_low(string tag);
    chk({tag, ".pulses"}, {next_wdma_valid_o, wdma_start_o, wdma_stop_o, sched_irq_o}, 4'b0000);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (next_wdma_valid_o) begin
        chk("valid_pending", exp_valid_q.size() > 0, 1);
        if (exp_valid_q.size() > 0)
          chk("valid_head", {next_wdma_up_addr_o, next_wdma_addr_o}, exp_valid_q.pop_front());
        valid_cyc = cyc;
      end
      if (wdma_start_o) begin
        chk("start_pending", exp_start > 0, 1);
        if (exp_start > 0) exp_start--;
        chk("start_lag", cyc - valid_cyc, 1);
      end
      if (wdma_stop_o) begin
        chk("stop_pending", exp_stop > 0, 1);
        if (exp_stop > 0) exp_stop--;
      end
      if (sched_irq_o) begin
        chk("irq_pending", exp_irq_q.size() > 0, 1);
        if (exp_irq_q.size() > 0)
          chk("irq_status_bufs", {sched_status_o, bufs_done_o}, exp_irq_q.pop_front());
        chk("irq_busy", sched_busy_o, 0);
      end
    end
  end

  initial begin
    d_t a, b;
    a = d_t'{up: 8'h10, addr: 32'h0000_1000, len: 16'd8};
    b = d_t'{up: 8'h10, addr: 32'h0000_2000, len: 16'd4};
    rst = 1; init_rst_i = 0; desc_wr_i = 0; sched_start_i = 0; sched_stop_i = 0;
    wdma_running_i = 0; wdma_irq_i = 0; wdma_status_i = 0;
    desc_addr_i = 0; desc_up_addr_i = 0; desc_len_i = 0;
    cur_run = 0; mon_en = 0;
    m_reset();
    idle(3);
    check_state("reset");
    check_pulses_low("reset");
    rst = 0; mon_en = 1;
    idle(1);

    start_sess();
    check_state("empty_start");

    push_desc(a);
    push_desc(b);
    start_sess();
    set_running(1);
    check_state("run_rise");

    irq_status(4'b0001, 0, rand_desc());
    check_state("status_done");

    irq_status(4'b0011, 0, rand_desc());
    check_state("terminal_0011");
    set_running(0);
    check_state("session_end");

    for (int i = 0; i < DEPTH + 1; i++) push_desc(rand_desc());
    check_state("overflow");
    start_sess();
    irq_status(4'b0001, 0, rand_desc());
    irq_status(4'b0001, 1, rand_desc());
    check_state("push_pop");
    push_desc(rand_desc());
    irq_status(4'b0001, 1, rand_desc());
    check_state("full_push_pop");
    while (mq.size() > 0) irq_status(4'b0001, 0, rand_desc());
    irq_status(4'b0010, 0, rand_desc());
    check_state("drained");

    push_desc(rand_desc());
    push_desc(rand_desc());
    start_sess();
    stop_sess();
    irq_status(4'b0100, 0, rand_desc());
    check_state("stopped");
    stop_sess();
    irq_status(4'b0001, 0, rand_desc());
    check_state("idle_ignores");

    for (int s = 0; s < 6; s++) begin
      int k, n;
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) push_desc(rand_desc());
      start_sess();
      n = $urandom_range(1, 5);
      for (int e = 0; e < n; e++) begin
        case ($urandom_range(0, 3))
          0: irq_status(4'b0001, bit'($urandom_range(0, 1)), rand_desc());
          1: begin set_running(1); set_running(0); end
          2: stop_sess();
          default: push_desc(rand_desc());
        endcase
      end
      case ($urandom_range(0, 3))
        0: irq_status(4'b0010, 0, rand_desc());
        1: irq_status(4'b0011, 0, rand_desc());
        2: irq_status(4'b0100, 0, rand_desc());
        default: irq_status(4'b1000, 0, rand_desc());
      endcase
      check_state("random_session");
    end

    init_rst_i = 1; desc_wr_i = 1; m_reset();
    step();
    init_rst_i = 0; desc_wr_i = 0;
    check_state("soft_reset_push");
    for (int i = 0; i < 3; i++) push_desc(rand_desc());
    start_sess();
    check_state("pre_soft_reset");
    init_rst_i = 1; sched_stop_i = 1; desc_wr_i = 1; m_reset();
    step();
    init_rst_i = 0; sched_stop_i = 0; desc_wr_i = 0;
    check_state("soft_reset_mid");
    check_pulses_low("soft_reset_mid");

    idle(5);
    chk("pending_valid", exp_valid_q.size(), 0);
    chk("pending_irq", exp_irq_q.size(), 0);
    chk("pending_start", exp_start, 0);
    chk("pending_stop", exp_stop, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
